// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: two bits per clock, MSB digit first, through one 2-bit cascade cell.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish as soon as the first differing digit is seen.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             b_gt_a,
    output logic             a_gt_b,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             eq_r;
    logic             gt_r;
    logic [CW-1:0]    cnt;

    logic [1:0]       da;
    logic [1:0]       db;
    logic             eq_n;
    logic             gt_n;
    logic             last;

    // 2-bit cascade cell: the top digit of each shifted operand against the flags so far.
    assign da   = sa[WIDTH-1 -: 2];
    assign db   = sb[WIDTH-1 -: 2];
    assign eq_n = eq_r & (da == db);
    assign gt_n = gt_r | (eq_r & (da < db));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign last = (cnt == CW'(1)) | ~eq_n;
`else
    assign last = (cnt == CW'(1));
`endif

    assign dbg_state = state;

    // Handshake: start is a one-cycle request honoured only in IDLE (ignored in RUN/DONE);
    // done is a one-cycle pulse marking the result flags as freshly loaded; busy is high in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            eq_r   <= 1'b1;
            gt_r   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_eq_b <= 1'b0;
            b_gt_a <= 1'b0;
            a_gt_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        eq_r  <= 1'b1;
                        gt_r  <= 1'b0;
                        cnt   <= CW'(N);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    eq_r <= eq_n;
                    gt_r <= gt_n;
                    sa   <= sa << 2;
                    sb   <= sb << 2;
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        a_eq_b <= eq_n;
                        b_gt_a <= gt_n;
                        a_gt_b <= ~eq_n & ~gt_n;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
